// File: rtl/anomaly_report_tx_if.sv
// rtl/anomaly_report_tx_if.sv - sample stream and anomaly flag feeding the report transmitter
interface anomaly_report_tx_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       anomaly_detected;

  modport master (output sample_in, output sample_valid, output anomaly_detected);
  modport slave  (input  sample_in, input  sample_valid, input  anomaly_detected);
endinterface

// File: rtl/anomaly_report_tx.sv
// rtl/anomaly_report_tx.sv - captures anomaly reports, queues them, sends 4-byte UART 8N1 frames
module anomaly_report_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  anomaly_report_tx_if.slave   s_in,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic [7:0]           event_count,
  output logic                 fifo_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0]   r_sample_count;
  logic [7:0]    r_last_sample;
  logic          r_anom_q;
  logic [7:0]    r_event_count;
  logic          r_fifo_overflow;
  logic [23:0]   r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fifo_cnt;
  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_frame;
  logic          r_tx_serial;
  logic          r_tx_busy;

  logic          w_event;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_bit_done;
  logic [7:0]    w_cur_byte;
  logic          w_line;

  assign w_event    = s_in.anomaly_detected & ~r_anom_q;
  assign w_empty    = (r_fifo_cnt == '0);
  assign w_full     = (r_fifo_cnt == C_DEPTH);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts the new report when the transmitter drains one this cycle.
  assign w_push     = w_event && (!w_full || w_pop);
  assign w_bit_done = (r_clk_cnt == C_LAST);

  always_comb begin
    w_cur_byte = HEADER_BYTE;
    case (r_byte_idx)
      2'd1:    w_cur_byte = r_frame[23:16];
      2'd2:    w_cur_byte = r_frame[15:8];
      2'd3:    w_cur_byte = r_frame[7:0];
      default: w_cur_byte = HEADER_BYTE;
    endcase
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START: w_line = 1'b0;
      S_DATA:  w_line = w_cur_byte[r_bit_idx];
      default: w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_count  <= '0;
      r_last_sample   <= '0;
      r_anom_q        <= 1'b0;
      r_event_count   <= '0;
      r_fifo_overflow <= 1'b0;
    end else begin
      r_anom_q <= s_in.anomaly_detected;
      if (s_in.sample_valid) begin
        r_last_sample  <= s_in.sample_in;
        r_sample_count <= r_sample_count + 16'd1;
      end
      if (w_event && (r_event_count != 8'hFF))
        r_event_count <= r_event_count + 8'd1;
      if (w_event && !w_push)
        r_fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo_mem[r_wr_ptr] <= {r_sample_count, r_last_sample};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW + 1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW + 1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Line and busy are registered one cycle behind the state, so the pop cycle itself is idle on the wire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_frame     <= '0;
      r_tx_serial <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      r_tx_serial <= w_line;
      r_tx_busy   <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_frame    <= r_fifo_mem[r_rd_ptr];
            r_byte_idx <= 2'd0;
            r_clk_cnt  <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7)
              r_state <= S_STOP;
            else
              r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_byte_idx != 2'd3) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_serial     = r_tx_serial;
  assign tx_busy       = r_tx_busy;
  assign event_count   = r_event_count;
  assign fifo_overflow = r_fifo_overflow;

endmodule

// File: doc/anomaly_report_tx.md
Name: anomaly_report_tx

Overview:
- Output-side companion to the anomaly-detection path. It watches the 8-bit sample stream and the anomaly_detected flag.
- On each new anomaly it captures a report: the sample index plus the last sample value.
- Reports are queued in a small FIFO and serialized off-chip as 4-byte UART (8N1) frames.
- Sits after the isolation-tree detector and is the transmit end of the anomaly reporting link.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (must be >= 2).
- FIFO_DEPTH, 4, report FIFO entries (power of 2, >= 2).
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- sample_in  input  8  sensor sample, same stream fed to the detector
- sample_valid  input  1  sample_in valid this cycle
- anomaly_detected  input  1  detector anomaly flag (level)
- tx_serial  output  1  UART line, idle high
- tx_busy  output  1  high while a frame is being shifted
- event_count  output  8  saturating count of detected anomaly events
- fifo_overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async):
  - tx_serial=1; tx_busy=0; event_count=0; fifo_overflow=0.
  - FIFO empty, sample_count=0, last_sample=0, anom_q=0, FSM=IDLE.
- Sample tracking:
  - On sample_valid: last_sample<=sample_in; sample_count (16-bit) increments.
  - sample_count wraps 16'hFFFF->0, no flag.
- Event detection:
  - anom_q<=anomaly_detected every cycle.
  - Event = anomaly_detected & ~anom_q, so a level held N cycles is one event.
- Capture:
  - On the event edge, push entry {sample_count, last_sample} (24 bits).
  - The entry uses register values before any same-cycle sample_valid update.
- event_count: increments on every event, dropped ones included; saturates at 255.
- FIFO:
  - Push succeeds if not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is discarded and fifo_overflow<=1. fifo_overflow clears only on reset.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the frame register, byte_idx=0, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles.
    - If byte_idx<3: byte_idx++ and go directly to START (no inter-byte gap).
    - Else: go to IDLE.
- Frame byte order: HEADER_BYTE, sample_count[15:8], sample_count[7:0], last_sample.
- Timing:
  - tx_serial is registered. A frame occupies exactly 40*CLKS_PER_BIT cycles.
  - IDLE lasts at least 1 cycle between frames.
- tx_busy: 1 from the cycle tx_serial first goes low (start bit of byte 0) through the last cycle of the byte-3 stop bit.
- Latency: with the FSM idle and FIFO empty, an event sampled at edge E gives tx_serial=0 from edge E+2.
- Simultaneous events:
  - Event and sample_valid in the same cycle: the captured index excludes that sample.
  - Event while transmitting: queued, not interleaved.
- Mid-operation reset: any frame is aborted immediately, tx_serial returns to 1, and queued reports are lost.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single event:
  - Stimulus: 3 samples 0x11,0x22,0x33, then anomaly_detected high 5 cycles.
  - Response: one frame A5,00,03,33 (160 cycles, LSB first); event_count=1; tx_serial low 2 edges after capture.
- Level vs edge:
  - Stimulus: anomaly_detected held high 500 cycles.
  - Response: exactly one frame; event_count=1.
- Overflow:
  - Stimulus: 6 one-cycle pulses spaced 3 cycles apart while idle.
  - Response: first is popped immediately, next 4 fill the FIFO, 6th dropped; fifo_overflow=1; event_count=6; exactly 5 frames out back-to-back with 1-cycle idle gaps.
- Wrap and same-cycle sample:
  - Stimulus: 65536 samples (count wraps to 0), then an event in the same cycle as sample_valid with 0x7E, previous sample 0x5A.
  - Response: frame A5,00,00,5A.
- Reset mid-frame:
  - Stimulus: assert reset during byte 1 DATA.
  - Response: tx_serial=1 and tx_busy=0 immediately; event_count=0; no further frames after release.
- Saturation:
  - Stimulus: 300 events.
  - Response: event_count=255.
